// File: rtl/pc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pc_pkg
// Brief  : Shared types and defaults for the program-counter stage: the run
//          state, the one-hot-free action encoding chosen each cycle, and the
//          default reset address.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    ACT_HOLD   = 3'd0,
    ACT_HALT   = 3'd1,
    ACT_RET    = 3'd2,
    ACT_CALL   = 3'd3,
    ACT_JUMP   = 3'd4,
    ACT_BRANCH = 3'd5,
    ACT_SEQ    = 3'd6
  } action_e;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/pc_unit_ras_stack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : ras_stack
// Brief  : Return-address stack. LIFO storage with an occupancy counter that
//          doubles as the stack pointer. Push while full and pop while empty
//          are ignored here; the caller decides how to flag them.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module ras_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [DW-1:0] depth_q;
  logic [DW-1:0] depth_d;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] top_idx;

  // Occupancy is the next free slot; the top entry sits one below it.
  assign push_idx = IW'(depth_q);
  assign top_idx  = IW'(depth_q - DW'(1));
  assign empty    = (depth_q == '0);
  assign full     = (depth_q == DW'(DEPTH));
  assign dout     = mem_q[top_idx];
  assign depth    = depth_q;

  // Next storage and occupancy; push takes precedence if both are requested.
  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (push && !full) begin
      mem_d[push_idx] = din;
      depth_d         = depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_d = depth_q - DW'(1);
    end
  end

  // Stack registers; reset empties the stack and clears stale entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      depth_q <= depth_d;
      mem_q   <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pc_unit
// Brief  : Program-counter stage. Chooses one action per cycle by fixed
//          priority (halt, ret, call, jump, branch, sequential), keeps the
//          registered pc, a RUN/HALTED state and sticky RAS error flags.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                RAS_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             halt,
  input  logic                             branch_taken,
  input  logic [ADDR_W-1:0]                branch_target,
  input  logic                             jump,
  input  logic                             call,
  input  logic                             ret,
  input  logic [ADDR_W-1:0]                jump_target,
  output logic [ADDR_W-1:0]                pc,
  output logic                             halted,
  output logic                             ras_overflow,
  output logic                             ras_underflow,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_depth
);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              unf_q;
  logic              unf_d;
  action_e           action;
  logic [ADDR_W-1:0] pc_plus1;
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_dout;
  logic              ras_full;
  logic              ras_empty;

  // Natural width truncation gives the modulo-2^ADDR_W wrap for free.
  assign pc_plus1 = pc_q + ADDR_W'(1);

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_plus1),
    .dout  (ras_dout),
    .depth (ras_depth),
    .full  (ras_full),
    .empty (ras_empty)
  );

  // Priority encoder: exactly one action per active cycle, HOLD otherwise.
  always_comb begin
    action = ACT_HOLD;
    if (state_q == RUN && !stall) begin
      if (halt)              action = ACT_HALT;
      else if (ret)          action = ACT_RET;
      else if (call)         action = ACT_CALL;
      else if (jump)         action = ACT_JUMP;
      else if (branch_taken) action = ACT_BRANCH;
      else                   action = ACT_SEQ;
    end
  end

  // Next state, pc, flags and stack requests for the selected action.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    case (action)
      ACT_HALT: state_d = HALTED;
      ACT_RET: begin
        if (!ras_empty) begin
          ras_pop = 1'b1;
          pc_d    = ras_dout;
        end else begin
          unf_d = 1'b1;
          pc_d  = pc_plus1;
        end
      end
      ACT_CALL: begin
        pc_d = jump_target;
        if (!ras_full) ras_push = 1'b1;
        else           ovf_d    = 1'b1;
      end
      ACT_JUMP:   pc_d = jump_target;
      ACT_BRANCH: pc_d = branch_target;
      ACT_SEQ:    pc_d = pc_plus1;
      default: ;
    endcase
  end

  // State, pc and sticky flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Ret outranks call, so the stack never sees a push and pop together;
  // a halted unit must never pick anything but HOLD.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(ras_push && ras_pop));
      assert (!(state_q == HALTED && action != ACT_HOLD));
    end
  end

  assign pc            = pc_q;
  assign halted        = (state_q == HALTED);
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_pc_unit
// Brief  : Self-checking bench for pc_unit: a behavioural model compared on
//          every falling edge, plus directed literal expectations.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        halt;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        jump;
  logic        call;
  logic        ret;
  logic [15:0] jump_target;
  logic [15:0] pc;
  logic        halted;
  logic        ras_overflow;
  logic        ras_underflow;
  logic [3:0]  ras_depth;

  int checks = 0;
  int errors = 0;

  pc_unit #(
    .ADDR_W    (16),
    .RESET_PC  (16'h0000),
    .RAS_DEPTH (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .halt          (halt),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .call          (call),
    .ret           (ret),
    .jump_target   (jump_target),
    .pc            (pc),
    .halted        (halted),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow),
    .ras_depth     (ras_depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: pc, a return-address array with occupancy, flags.
  typedef struct packed {
    logic [15:0]      pc;
    logic [7:0][15:0] stk;
    logic [3:0]       depth;
    logic             halted;
    logic             ovf;
    logic             unf;
  } model_t;

  model_t m;

  function automatic model_t model_step(input model_t cur);
    model_t n;
    n = cur;
    if (cur.halted || stall) return n;
    if (halt) begin
      n.halted = 1'b1;
    end else if (ret) begin
      if (cur.depth != 0) begin
        n.pc    = cur.stk[cur.depth - 1];
        n.depth = cur.depth - 4'd1;
      end else begin
        n.unf = 1'b1;
        n.pc  = cur.pc + 16'd1;
      end
    end else if (call) begin
      n.pc = jump_target;
      if (cur.depth < 8) begin
        n.stk[cur.depth[2:0]] = cur.pc + 16'd1;
        n.depth               = cur.depth + 4'd1;
      end else begin
        n.ovf = 1'b1;
      end
    end else if (jump) begin
      n.pc = jump_target;
    end else if (branch_taken) begin
      n.pc = branch_target;
    end else begin
      n.pc = cur.pc + 16'd1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= model_step(m);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every falling edge: DUT outputs must match the model.
  always @(negedge clk) begin
    chk("model_pc",  32'(pc),            32'(m.pc));
    chk("model_hlt", 32'(halted),        32'(m.halted));
    chk("model_ovf", 32'(ras_overflow),  32'(m.ovf));
    chk("model_unf", 32'(ras_underflow), 32'(m.unf));
    chk("model_dep", 32'(ras_depth),     32'(m.depth));
  end

  task automatic idle();
    stall = 0; halt = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic goto(input logic [15:0] a);
    idle(); jump = 1; jump_target = a; cyc(); idle();
  endtask

  initial begin
    reset = 1; branch_target = 0; jump_target = 0;
    idle();
    #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_depth", 32'(ras_depth), 32'h0);
    #11 reset = 0;
    #1 chk("run_pc0", 32'(pc), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("run_seq", 32'(pc), 32'(i));
    end

    // Stall holds pc even with a taken branch presented.
    goto(16'h0010);
    stall = 1; branch_taken = 1; branch_target = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hold", 32'(pc), 32'h0010);
    end
    stall = 0; cyc(); idle();
    chk("branch", 32'(pc), 32'h0040);

    // Call then return.
    goto(16'h0020);
    call = 1; jump_target = 16'h0100; cyc(); idle();
    chk("call_pc", 32'(pc), 32'h0100);
    chk("call_depth", 32'(ras_depth), 32'h1);
    cyc(); cyc();
    chk("pre_ret_pc", 32'(pc), 32'h0102);
    ret = 1; cyc(); idle();
    chk("ret_pc", 32'(pc), 32'h0021);
    chk("ret_depth", 32'(ras_depth), 32'h0);

    // Nested calls with distinct return addresses come back LIFO.
    call = 1; jump_target = 16'h0300; cyc();
    jump_target = 16'h0310; cyc();
    jump_target = 16'h0320; cyc(); idle();
    ret = 1;
    cyc(); chk("lifo0", 32'(pc), 32'h0311);
    cyc(); chk("lifo1", 32'(pc), 32'h0301);
    cyc(); chk("lifo2", 32'(pc), 32'h0022);
    idle();

    // Nine calls: the ninth overflows. Nine rets: the ninth underflows.
    call = 1; jump_target = 16'h0200;
    for (int i = 0; i < 9; i++) cyc();
    idle();
    chk("ovf_pc", 32'(pc), 32'h0200);
    chk("ovf_depth", 32'(ras_depth), 32'h8);
    chk("ovf_flag", 32'(ras_overflow), 32'h1);
    ret = 1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("pop_pc", 32'(pc), (i < 7) ? 32'h0201 : (i == 7) ? 32'h0023 : 32'h0024);
    end
    idle();
    chk("unf_flag", 32'(ras_underflow), 32'h1);
    chk("unf_depth", 32'(ras_depth), 32'h0);

    // Wrap of pc and of the pushed return address; jump beats branch.
    goto(16'hFFFF);
    cyc(); chk("wrap_seq", 32'(pc), 32'h0000);
    goto(16'hFFFF);
    call = 1; jump_target = 16'h0500; cyc(); idle();
    ret = 1; cyc(); idle();
    chk("wrap_ret", 32'(pc), 32'h0000);
    jump = 1; branch_taken = 1; jump_target = 16'h0AAA; branch_target = 16'h0BBB;
    cyc(); idle();
    chk("jump_prio", 32'(pc), 32'h0AAA);

    // Halt beats call; halted ignores everything afterwards.
    call = 1; jump_target = 16'h002F; cyc(); idle();
    cyc();
    chk("pre_halt_pc", 32'(pc), 32'h0030);
    halt = 1; call = 1; jump_target = 16'h0700; cyc(); idle();
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_pc", 32'(pc), 32'h0030);
    chk("halt_depth", 32'(ras_depth), 32'h1);
    jump = 1; ret = 1; call = 1; branch_taken = 1;
    for (int i = 0; i < 3; i++) cyc();
    idle();
    chk("halt_frozen_pc", 32'(pc), 32'h0030);
    chk("halt_frozen_dep", 32'(ras_depth), 32'h1);

    // Asynchronous reset mid-cycle.
    reset = 1;
    #1;
    chk("areset_pc", 32'(pc), 32'h0);
    chk("areset_halted", 32'(halted), 32'h0);
    chk("areset_ovf", 32'(ras_overflow), 32'h0);
    chk("areset_unf", 32'(ras_underflow), 32'h0);
    chk("areset_depth", 32'(ras_depth), 32'h0);
    cyc();
    reset = 0;
    cyc();
    chk("post_reset_pc", 32'(pc), 32'h1);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
